// File: rtl/frv_mem_pkg.sv
// Shared types and constants for the frv memory responder.
// Optional build macro used by the top level: FRV_MEM_RANGE_CHECK_EN.
package frv_mem_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   // Wide enough for the largest supported latency (15).
   localparam int AGE_W  = 4;

   // One queued response: read data, bus error flag and cycles since accept.
   typedef struct packed {
      logic [DATA_W-1:0] rdata;
      logic              error;
      logic [AGE_W-1:0]  age;
   } rsp_entry_t;

   // Word index width for an array of the given depth.
   function automatic int idx_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/frv_mem_responder_if.sv
// Request/response bus between the core (master) and the memory responder (slave).
interface frv_mem_responder_if;
   import frv_mem_pkg::*;

   logic              mem_req;
   logic              mem_wen;
   logic [3:0]        mem_strb;
   logic [DATA_W-1:0] mem_wdata;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_gnt;
   logic              mem_recv;
   logic              mem_ack;
   logic              mem_error;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_req, mem_wen, mem_strb, mem_wdata, mem_addr, mem_ack,
      input  mem_gnt, mem_recv, mem_error, mem_rdata
   );

   modport slave (
      input  mem_req, mem_wen, mem_strb, mem_wdata, mem_addr, mem_ack,
      output mem_gnt, mem_recv, mem_error, mem_rdata
   );

endinterface

// File: rtl/frv_mem_rsp_fifo.sv
// In-order response queue. Every slot ages in parallel and saturates at
// LATENCY, so once the head retires the next entry may already be ready.
module frv_mem_rsp_fifo
   import frv_mem_pkg::*;
#(
   parameter  int DEPTH   = 2,
   parameter  int LATENCY = 1,
   localparam int CNT_W   = $clog2(DEPTH + 1),
   localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [DATA_W-1:0] push_rdata,
   input  logic              push_error,
   input  logic              pop,
   output logic [CNT_W-1:0]  count,
   output logic              head_ready,
   output rsp_entry_t        head
);

   localparam logic [AGE_W-1:0] LAT = AGE_W'(LATENCY);

   rsp_entry_t       ents [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;

   function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign head       = ents[rd_ptr];
   assign head_ready = (count != '0) && (head.age == LAT);

   // Age all slots, load pushed entries with age 0, advance pointers and count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) ents[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++)
            if (ents[i].age != LAT) ents[i].age <= ents[i].age + 1'b1;
         if (push) begin
            ents[wr_ptr] <= '{rdata: push_rdata, error: push_error, age: '0};
            wr_ptr       <= nxt(wr_ptr);
         end
         if (pop) rd_ptr <= nxt(rd_ptr);
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

endmodule

// File: rtl/frv_mem_responder.sv
// Memory-side responder: word array, grant logic, optional address range check
// (enabled by defining FRV_MEM_RANGE_CHECK_EN) and an in-order response queue.
module frv_mem_responder
   import frv_mem_pkg::*;
#(
   parameter int          DEPTH_WORDS     = 1024,
   parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
   parameter int          LATENCY         = 1,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic g_clk,
   input  logic g_resetn,
   frv_mem_responder_if.slave bus
);

   localparam int IDX_W = idx_width(DEPTH_WORDS);
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

   logic [DATA_W-1:0] mem [DEPTH_WORDS];
   logic [IDX_W-1:0]  idx;
   logic              accept;
   logic              rsp_err;
   logic              wr_ok;
   logic [CNT_W-1:0]  count;
   logic              head_ready;
   rsp_entry_t        head;

   // Word index wraps modulo the array size.
   assign idx = IDX_W'((bus.mem_addr - BASE_ADDR) >> 2);

`ifdef FRV_MEM_RANGE_CHECK_EN
   // 33-bit difference: an address below BASE_ADDR wraps high and fails the compare.
   logic in_range;
   assign in_range = ({1'b0, bus.mem_addr} - {1'b0, BASE_ADDR}) < ((ADDR_W + 1)'(DEPTH_WORDS) << 2);
   assign rsp_err  = !in_range;
   assign wr_ok    = in_range;
`else
   assign rsp_err  = 1'b0;
   assign wr_ok    = 1'b1;
`endif

   // No bypass: a slot freed by this cycle's pop only shows up next cycle.
   assign bus.mem_gnt = g_resetn && bus.mem_req && (count < CNT_W'(MAX_OUTSTANDING));
   assign accept      = bus.mem_gnt;

   // Byte-strobed write at the accept edge; the array itself is never reset.
   always_ff @(posedge g_clk) begin
      if (accept && bus.mem_wen && wr_ok)
         for (int b = 0; b < 4; b++)
            if (bus.mem_strb[b]) mem[idx][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
   end

   frv_mem_rsp_fifo #(
      .DEPTH   (MAX_OUTSTANDING),
      .LATENCY (LATENCY)
   ) u_fifo (
      .clk        (g_clk),
      .rst_n      (g_resetn),
      .push       (accept),
      .push_rdata ((!bus.mem_wen && wr_ok) ? mem[idx] : '0),
      .push_error (rsp_err),
      .pop        (head_ready && bus.mem_ack),
      .count      (count),
      .head_ready (head_ready),
      .head       (head)
   );

   // Head stays put until acked, so recv/rdata/error are stable while pending.
   assign bus.mem_recv  = head_ready;
   assign bus.mem_rdata = head_ready ? head.rdata : '0;
   assign bus.mem_error = head_ready ? head.error : 1'b0;

endmodule

// File: tb/tb_frv_mem_responder.sv
// Directed bench: dut_a (LATENCY=1, MAX_OUTSTANDING=2), dut_b (LATENCY=3).
module tb_frv_mem_responder;

   logic g_clk    = 1'b0;
   logic g_resetn = 1'b0;
   int   total    = 0;
   int   bad      = 0;

   always #5 g_clk = ~g_clk;

   frv_mem_responder_if a_if ();
   frv_mem_responder_if b_if ();

   frv_mem_responder #(
      .DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(1), .MAX_OUTSTANDING(2)
   ) dut_a (.g_clk(g_clk), .g_resetn(g_resetn), .bus(a_if));

   frv_mem_responder #(
      .DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(3), .MAX_OUTSTANDING(2)
   ) dut_b (.g_clk(g_clk), .g_resetn(g_resetn), .bus(b_if));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge g_clk);
      #1;
   endtask

   task automatic a_drive(input logic req, input logic wen, input logic [3:0] strb,
                          input logic [31:0] wdata, input logic [31:0] addr);
      a_if.mem_req = req; a_if.mem_wen = wen; a_if.mem_strb = strb;
      a_if.mem_wdata = wdata; a_if.mem_addr = addr;
   endtask

   task automatic b_drive(input logic req, input logic wen, input logic [3:0] strb,
                          input logic [31:0] wdata, input logic [31:0] addr);
      b_if.mem_req = req; b_if.mem_wen = wen; b_if.mem_strb = strb;
      b_if.mem_wdata = wdata; b_if.mem_addr = addr;
   endtask

   // Single transaction on dut_a from an empty queue, ack held high.
   task automatic a_xact(input string tag, input logic wen, input logic [3:0] strb,
                         input logic [31:0] wdata, input logic [31:0] addr,
                         input logic [31:0] exp_rdata, input logic exp_err);
      a_if.mem_ack = 1'b1;
      a_drive(1'b1, wen, strb, wdata, addr);
      #1 chk({tag, ".gnt"}, 32'(a_if.mem_gnt), 32'd1);
      tick();
      a_drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      #1 chk({tag, ".recv0"}, 32'(a_if.mem_recv), 32'd0);
      tick();
      chk({tag, ".recv1"}, 32'(a_if.mem_recv), 32'd1);
      chk({tag, ".rdata"}, a_if.mem_rdata, exp_rdata);
      chk({tag, ".error"}, 32'(a_if.mem_error), 32'(exp_err));
      tick();
      chk({tag, ".retired"}, 32'(a_if.mem_recv), 32'd0);
   endtask

   initial begin
      a_drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0); a_if.mem_ack = 1'b0;
      b_drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0); b_if.mem_ack = 1'b0;

      // reset state
      #3;
      chk("rst.gnt",   32'(a_if.mem_gnt),   32'd0);
      chk("rst.recv",  32'(a_if.mem_recv),  32'd0);
      chk("rst.error", 32'(a_if.mem_error), 32'd0);
      chk("rst.rdata", a_if.mem_rdata,      32'd0);
      #5 g_resetn = 1'b1;
      tick();

      // write DEADBEEF then read it back-to-back, ack high
      a_if.mem_ack = 1'b1;
      a_drive(1'b1, 1'b1, 4'hF, 32'hDEADBEEF, 32'h10);
      #1 chk("t1.wr_gnt", 32'(a_if.mem_gnt), 32'd1);
      tick();
      a_drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h10);
      #1 chk("t1.rd_gnt", 32'(a_if.mem_gnt), 32'd1);
      chk("t1.recv_early", 32'(a_if.mem_recv), 32'd0);
      tick();
      a_drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      #1 chk("t1.wr_recv", 32'(a_if.mem_recv), 32'd1);
      chk("t1.wr_rdata", a_if.mem_rdata, 32'd0);
      chk("t1.wr_err", 32'(a_if.mem_error), 32'd0);
      tick();
      chk("t1.rd_recv", 32'(a_if.mem_recv), 32'd1);
      chk("t1.rd_rdata", a_if.mem_rdata, 32'hDEADBEEF);
      tick();
      chk("t1.idle", 32'(a_if.mem_recv), 32'd0);

      // partial write
      a_xact("t2.wr_full", 1'b1, 4'hF, 32'h11223344, 32'h20, 32'h0, 1'b0);
      a_xact("t2.wr_part", 1'b1, 4'b0010, 32'h0000AB00, 32'h20, 32'h0, 1'b0);
      a_xact("t2.rd", 1'b0, 4'h0, 32'h0, 32'h20, 32'h1122AB44, 1'b0);

      // full queue back-pressure and in-order retirement
      a_xact("t3.pre0", 1'b1, 4'hF, 32'hA0A0A0A0, 32'h30, 32'h0, 1'b0);
      a_xact("t3.pre1", 1'b1, 4'hF, 32'hA1A1A1A1, 32'h34, 32'h0, 1'b0);
      a_xact("t3.pre2", 1'b1, 4'hF, 32'hA2A2A2A2, 32'h38, 32'h0, 1'b0);
      a_if.mem_ack = 1'b0;
      a_drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h30);
      #1 chk("t3.gnt0", 32'(a_if.mem_gnt), 32'd1);
      tick();
      a_if.mem_addr = 32'h34;
      #1 chk("t3.gnt1", 32'(a_if.mem_gnt), 32'd1);
      tick();
      a_if.mem_addr = 32'h38;
      #1 chk("t3.gnt2_full", 32'(a_if.mem_gnt), 32'd0);
      chk("t3.head0", a_if.mem_rdata, 32'hA0A0A0A0);
      tick();
      chk("t3.gnt2_still", 32'(a_if.mem_gnt), 32'd0);
      chk("t3.head0_held", a_if.mem_rdata, 32'hA0A0A0A0);
      a_if.mem_ack = 1'b1;
      #1 chk("t3.no_bypass", 32'(a_if.mem_gnt), 32'd0);
      tick();
      a_if.mem_ack = 1'b0;
      #1 chk("t3.gnt_reassert", 32'(a_if.mem_gnt), 32'd1);
      chk("t3.head1", a_if.mem_rdata, 32'hA1A1A1A1);
      tick();
      a_drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      #1 chk("t3.head1_held", a_if.mem_rdata, 32'hA1A1A1A1);
      a_if.mem_ack = 1'b1;
      tick();
      chk("t3.head2", a_if.mem_rdata, 32'hA2A2A2A2);
      tick();
      chk("t3.drained", 32'(a_if.mem_recv), 32'd0);

      // LATENCY=3 on dut_b
      b_if.mem_ack = 1'b1;
      b_drive(1'b1, 1'b1, 4'hF, 32'h13579BDF, 32'h8);
      #1 chk("t4.wr_gnt", 32'(b_if.mem_gnt), 32'd1);
      tick();
      b_drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      tick(); chk("t4.wr_c1", 32'(b_if.mem_recv), 32'd0);
      tick(); chk("t4.wr_c2", 32'(b_if.mem_recv), 32'd0);
      tick(); chk("t4.wr_c3", 32'(b_if.mem_recv), 32'd1);
      tick(); chk("t4.wr_pop", 32'(b_if.mem_recv), 32'd0);
      b_if.mem_ack = 1'b0;
      b_drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h8);
      #1 chk("t4.rd_gnt", 32'(b_if.mem_gnt), 32'd1);
      tick();
      b_drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      tick(); chk("t4.rd_c1", 32'(b_if.mem_recv), 32'd0);
      tick(); chk("t4.rd_c2", 32'(b_if.mem_recv), 32'd0);
      for (int c = 3; c <= 6; c++) begin
         tick();
         chk($sformatf("t4.recv_c%0d", c), 32'(b_if.mem_recv), 32'd1);
         chk($sformatf("t4.rdata_c%0d", c), b_if.mem_rdata, 32'h13579BDF);
      end
      b_if.mem_ack = 1'b1;
      tick();
      chk("t4.rd_pop", 32'(b_if.mem_recv), 32'd0);
      b_if.mem_ack = 1'b0;

      // asynchronous reset with two responses queued
      a_xact("t5.wr", 1'b1, 4'hF, 32'h5A5A5A5A, 32'h40, 32'h0, 1'b0);
      a_if.mem_ack = 1'b0;
      a_drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h40);
      tick();
      tick();
      a_drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      #1 chk("t5.queued", 32'(a_if.mem_recv), 32'd1);
      g_resetn = 1'b0;
      #1 chk("t5.async_recv", 32'(a_if.mem_recv), 32'd0);
      chk("t5.async_rdata", a_if.mem_rdata, 32'd0);
      tick();
      g_resetn = 1'b1;
      tick();
      tick();
      chk("t5.no_stale", 32'(a_if.mem_recv), 32'd0);
      a_xact("t5.rd_kept", 1'b0, 4'h0, 32'h0, 32'h40, 32'h5A5A5A5A, 1'b0);

      // out-of-range address 0x1000 (one past the array)
      a_xact("t6.wr0", 1'b1, 4'hF, 32'hCAFEF00D, 32'h0, 32'h0, 1'b0);
`ifdef FRV_MEM_RANGE_CHECK_EN
      a_xact("t6.rd_oor", 1'b0, 4'h0, 32'h0, 32'h1000, 32'h0, 1'b1);
      a_xact("t6.wr_oor", 1'b1, 4'hF, 32'hFFFFFFFF, 32'h1000, 32'h0, 1'b1);
      a_xact("t6.rd0", 1'b0, 4'h0, 32'h0, 32'h0, 32'hCAFEF00D, 1'b0);
`else
      a_xact("t6.rd_wrap", 1'b0, 4'h0, 32'h0, 32'h1000, 32'hCAFEF00D, 1'b0);
      a_xact("t6.wr_wrap", 1'b1, 4'hF, 32'hFFFFFFFF, 32'h1000, 32'h0, 1'b0);
      a_xact("t6.rd0", 1'b0, 4'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/frv_mem_responder.md
Name: frv_mem_responder

Overview:
- Memory-side responder for the core's imem/dmem request/response bus (req/gnt request phase, recv/ack response phase).
- Accepts granted requests, performs them on an internal word array, and returns in-order responses after a fixed latency.
- Used as the instruction or data memory model in simulation benches and as a bounded responder in formal runs.
- Supports several outstanding transactions and back-pressure on both phases.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two, >= 2).
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0 (4-byte aligned).
- LATENCY, 1, minimum cycles from the accept edge to first mem_recv assertion (range 1..15).
- MAX_OUTSTANDING, 2, response queue depth (power of two, 1..8).

Ports:
- g_clk  in  1  clock; all state updates on the rising edge.
- g_resetn  in  1  asynchronous active-low reset.
- mem_req  in  1  initiator requests a transaction.
- mem_wen  in  1  write enable (1 = write, 0 = read).
- mem_strb  in  4  byte write strobes; bit i selects wdata[8i+7:8i].
- mem_wdata  in  32  write data.
- mem_addr  in  32  byte address; bits [1:0] ignored.
- mem_gnt  out  1  request accepted this cycle.
- mem_recv  out  1  response valid.
- mem_ack  in  1  initiator accepts the response.
- mem_error  out  1  response carries a bus error.
- mem_rdata  out  32  read data for the response.

Behaviour:
- Reset: mem_gnt=0, mem_recv=0, mem_error=0, mem_rdata=0, queue empty, all age counters 0. Array contents are not reset.
- Grant: mem_gnt = mem_req && (count < MAX_OUTSTANDING), combinational. A slot freed by a pop in the same cycle does not raise gnt; no bypass.
- Accept: occurs on an edge where mem_req && mem_gnt.
  - Write: bytes with strb=1 are written at the accept edge; the response has rdata=0.
  - Read: the word is sampled at the accept edge, so a read accepted after a write sees the written data.
- Index: (mem_addr - BASE_ADDR) >> 2, modulo DEPTH_WORDS.
- Queue entry: {rdata, error, age}. age starts at 0 and saturates at LATENCY.
- Response:
  - mem_recv = queue not empty && head.age == LATENCY.
  - mem_rdata and mem_error come from the head entry. They are 0 when mem_recv=0.
  - Pop on mem_recv && mem_ack.
  - Once raised, recv, rdata and error are held stable until ack.
- Ordering: strictly in-order; accepted transactions retire in acceptance order.
- Simultaneous accept and pop: both take effect; count is unchanged.
- Full queue: gnt held low; mem_req may stay high and is granted on the cycle after count drops.
- Non-head entries age in parallel, so back-to-back responses are possible when ack is held high.
- Reset mid-operation: queue flushed, pending responses discarded. Writes already accepted remain in the array.

Optional Feature:
- Macro: FRV_MEM_RANGE_CHECK_EN
- Defined: a request with byte address outside [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS) is still granted and queued with error=1 and rdata=0, and no write occurs.
- Undefined: no range check; addresses wrap modulo the array size and mem_error is always 0.

Decomposition:
- Package frv_mem_pkg holds:
  - the response entry struct (rdata, error, age);
  - the ADDR_W and DATA_W constants;
  - an index width function, clog2(DEPTH_WORDS).
- Sub-module frv_mem_rsp_fifo: parameterised in-order queue with count, per-entry age counters, head-ready flag, and push/pop ports.
- Top level holds the array, the grant logic and the range check.

Test Plan:
- Write 0xDEADBEEF to 0x10 (strb=4'hF), then read 0x10 with ack tied high, LATENCY=1 -> write response recv 1 cycle after accept with rdata=0; read response rdata=0xDEADBEEF.
- Partial write strb=4'b0010, wdata=0x0000AB00, to a word holding 0x11223344 -> subsequent read returns 0x1122AB44.
- MAX_OUTSTANDING=2, ack held low, req held high for 3 reads -> gnt high for the first two only. Raise ack for 1 cycle -> one pop, gnt reasserts on the next cycle. Responses return in order.
- LATENCY=3, single read at cycle 0 -> recv first asserts at cycle 3. With ack low until cycle 6, recv and rdata are held constant over cycles 3..6.
- Assert g_resetn low with 2 responses queued -> recv=0 immediately (asynchronous). After release no stale response appears, and earlier written data still reads back.
- With FRV_MEM_RANGE_CHECK_EN, DEPTH_WORDS=1024: read of 0x1000 -> error=1, rdata=0; write to 0x1000 leaves word 0 unchanged. Without the macro, a read of 0x1000 returns word 0 with error=0.
